// File: rtl/apple_disk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple_disk_pkg
// Description : Shared types and geometry constants for the track cache.
// Revision    : 1.0 - initial release
// ============================================================================
package apple_disk_pkg;

    localparam int BLOCK_BYTES              = 512;
    localparam int TRACK_BYTES              = 6656;
    localparam int DEFAULT_BLOCKS_PER_TRACK = TRACK_BYTES / BLOCK_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_XFER = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_XFER = 3'd4
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/apple_track_ram.sv
`default_nettype none
// ============================================================================
// Module      : apple_track_ram
// Description : True dual-port RAM, registered read data on both ports.
// Revision    : 1.0 - initial release
// ============================================================================
module apple_track_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_din,
    input  logic              i_a_we,
    output logic [DATA_W-1:0] o_a_dout,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_din,
    input  logic              i_b_we,
    output logic [DATA_W-1:0] o_b_dout
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] a_dout_d, a_dout_q;
    logic [DATA_W-1:0] b_dout_d, b_dout_q;

    always_comb begin
        a_dout_d = mem[i_a_addr];
        b_dout_d = mem[i_b_addr];
    end

    // The two writers are never active together; read data is the pre-write value.
    always_ff @(posedge clk) begin
        if (i_a_we) mem[i_a_addr] <= i_a_din;
        if (i_b_we) mem[i_b_addr] <= i_b_din;
        if (rst) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign o_a_dout = a_dout_q;
    assign o_b_dout = b_dout_q;

endmodule
`default_nettype wire

// File: rtl/apple_track_buffer.sv
`default_nettype none
// ============================================================================
// Module      : apple_track_buffer
// Description : Track cache between the block device and the drive model.
// Revision    : 1.0 - initial release
// ============================================================================
module apple_track_buffer
    import apple_disk_pkg::*;
#(
    parameter int          BLOCKS_PER_TRACK = DEFAULT_BLOCKS_PER_TRACK,
    parameter logic [31:0] LBA_BASE         = 32'd0
) (
    input  logic        CLK_14M,
    input  logic        RESET,
    input  logic        DISK_MOUNTED,
    input  logic [6:0]  TRACK,
    input  logic [12:0] TRACK_ADDR,
    input  logic [7:0]  TRACK_DI,
    input  logic        TRACK_WE,
    output logic [7:0]  TRACK_DO,
    output logic        TRACK_BUSY,
    output logic        DISK_READY,
    output logic [31:0] SD_LBA,
    output logic        SD_RD,
    output logic        SD_WR,
    input  logic        SD_ACK,
    input  logic [8:0]  SD_BUFF_ADDR,
    input  logic [7:0]  SD_BUFF_DOUT,
    input  logic        SD_BUFF_WR,
    output logic [7:0]  SD_BUFF_DIN
);

    localparam logic [3:0] c_last_blk = 4'(BLOCKS_PER_TRACK - 1);

    loader_state_e state_q, state_d;
    logic          valid_q, valid_d;
    logic          dirty_q, dirty_d;
    logic [6:0]    cur_track_q, cur_track_d;
    logic [3:0]    blk_q, blk_d;
    logic          sd_ack_q, sd_ack_d;

    logic          w_busy;
    logic          w_ack_fall;
    logic          w_drive_we;
    logic          w_host_we;
    logic [31:0]   w_lba;

    assign w_busy     = (state_q != ST_IDLE);
    assign w_ack_fall = sd_ack_q & ~SD_ACK;
    assign w_drive_we = TRACK_WE & ~w_busy & valid_q & ~RESET;
    assign w_host_we  = (state_q == ST_RD_XFER) & SD_BUFF_WR;
    assign w_lba      = LBA_BASE + 32'(cur_track_q) * 32'(BLOCKS_PER_TRACK) + 32'(blk_q);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q | w_drive_we;
        cur_track_d = cur_track_q;
        blk_d       = blk_q;
        sd_ack_d    = SD_ACK;

        case (state_q)
            ST_IDLE: begin
                if (!DISK_MOUNTED) begin
                    valid_d = 1'b0;
                    dirty_d = 1'b0;
                end else if (!valid_q || (TRACK != cur_track_q)) begin
                    blk_d = 4'd0;
                    if (dirty_q && valid_q) begin
                        state_d = ST_WR_REQ;
                    end else begin
                        cur_track_d = TRACK;
                        valid_d     = 1'b0;
                        state_d     = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ, ST_WR_REQ: begin
                // An unmount only aborts before the host has taken the request.
                if (SD_ACK) begin
                    state_d = (state_q == ST_RD_REQ) ? ST_RD_XFER : ST_WR_XFER;
                end else if (!DISK_MOUNTED) begin
                    valid_d = 1'b0;
                    dirty_d = 1'b0;
                    blk_d   = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_XFER: begin
                if (w_ack_fall) begin
                    if (!DISK_MOUNTED) begin
                        valid_d = 1'b0;
                        dirty_d = 1'b0;
                        blk_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else if (blk_q == c_last_blk) begin
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_XFER: begin
                if (w_ack_fall) begin
                    if (!DISK_MOUNTED) begin
                        valid_d = 1'b0;
                        dirty_d = 1'b0;
                        blk_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else if (blk_q == c_last_blk) begin
                        dirty_d     = 1'b0;
                        valid_d     = 1'b0;
                        cur_track_d = TRACK;
                        blk_d       = 4'd0;
                        state_d     = ST_RD_REQ;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            cur_track_q <= 7'd0;
            blk_q       <= 4'd0;
            sd_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cur_track_q <= cur_track_d;
            blk_q       <= blk_d;
            sd_ack_q    <= sd_ack_d;
        end
    end

    assign TRACK_BUSY = w_busy;
    assign DISK_READY = valid_q & DISK_MOUNTED & ~w_busy;
    assign SD_RD      = (state_q == ST_RD_REQ);
    assign SD_WR      = (state_q == ST_WR_REQ);
    assign SD_LBA     = w_busy ? w_lba : 32'd0;

    apple_track_ram #(
        .ADDR_W (13),
        .DATA_W (8)
    ) u_ram (
        .clk      (CLK_14M),
        .rst      (RESET),
        .i_a_addr (TRACK_ADDR),
        .i_a_din  (TRACK_DI),
        .i_a_we   (w_drive_we),
        .o_a_dout (TRACK_DO),
        .i_b_addr ({blk_q, SD_BUFF_ADDR}),
        .i_b_din  (SD_BUFF_DOUT),
        .i_b_we   (w_host_we),
        .o_b_dout (SD_BUFF_DIN)
    );

endmodule
`default_nettype wire
